// File: rtl/pmic_pkg.sv
// ---------------------------------------------------------------------------
// pmic_pkg
// Shared definitions for the PMIC power supervisor:
//   - sup_state_t    : supervisor state encoding
//   - FC_*           : fault_code values reported to the host
//   - DEF_*          : default parameter values for the supervisor and filters
//   - cnt_width()    : counter width helper (never narrower than one bit)
// ---------------------------------------------------------------------------
package pmic_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_POWER_UP = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_SHUTDOWN = 3'd3,
        ST_COOLDOWN = 3'd4,
        ST_LOCKOUT  = 3'd5
    } sup_state_t;

    localparam logic [1:0] FC_NONE       = 2'd0;
    localparam logic [1:0] FC_LOW_BAT    = 2'd1;
    localparam logic [1:0] FC_LOW_POW    = 2'd2;
    localparam logic [1:0] FC_PU_TIMEOUT = 2'd3;

    localparam int DEF_DEBOUNCE_CYC = 16;
    localparam int DEF_COOLDOWN_CYC = 1024;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_PU_TIMEOUT   = 4096;

    // Width of a counter that must reach n-1; a 1-cycle parameter still
    // needs a one-bit register so the comparison logic stays well formed.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmic_debounce.sv
// ---------------------------------------------------------------------------
// pmic_debounce
// Two-flop synchroniser followed by a debounce filter. The filtered level
// only changes after DEBOUNCE_CYC consecutive synchronised samples that all
// disagree with it, so a clean raw edge takes 2+DEBOUNCE_CYC cycles to land.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   raw        in   unsynchronised input
//   filt_next  out  value the filtered level takes at the next rising edge;
//                   lets the supervisor act on the same edge the filter
//                   commits, keeping the end-to-end latency at 2+DEBOUNCE_CYC
// ---------------------------------------------------------------------------
module pmic_debounce
    import pmic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt_next
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          filt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            filt    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            filt    <= filt_next;
            cnt     <= cnt_next;
        end
    end

    // cnt holds the number of disagreeing samples already seen; any
    // agreeing sample restarts the run.
    always_comb begin
        filt_next = filt;
        cnt_next  = '0;
        if (sync_p1 != filt) begin
            if (cnt == CNT_LAST) begin
                filt_next = sync_p1;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pmic_power_supervisor.sv
// ---------------------------------------------------------------------------
// pmic_power_supervisor
// Filters the user ON/OFF switch and the two supply-fault comparators, then
// runs the power state machine (OFF, POWER_UP, RUNNING, SHUTDOWN, COOLDOWN,
// LOCKOUT) that commands the LDO sequencer and applies retry/lockout policy
// to fault shutdowns.
//
// Build option:
//   PMIC_SUP_WATCHDOG_EN  when defined, POWER_UP is bounded by PU_TIMEOUT
//                         cycles; expiry without seq_ready is fault code 3.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   on_off_raw    in   user ON/OFF switch (unsynchronised)
//   low_bat_raw   in   battery-low comparator (unsynchronised)
//   low_pow_raw   in   input-power-low comparator (unsynchronised)
//   seq_ready     in   LDO sequencer reports rails up
//   seq_idle      in   LDO sequencer reports all rails off
//   on_cmd        out  ON request to the sequencer
//   fault_active  out  fault shutdown in progress (until cooldown ends)
//   fault_code    out  0 none, 1 low_bat, 2 low_pow, 3 power-up timeout
//   retry_cnt     out  fault restarts since the last clean OFF
//   lockout       out  retries exhausted; waiting for the user to switch OFF
// ---------------------------------------------------------------------------
module pmic_power_supervisor
    import pmic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int PU_TIMEOUT   = DEF_PU_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on_off_raw,
    input  logic       low_bat_raw,
    input  logic       low_pow_raw,
    input  logic       seq_ready,
    input  logic       seq_idle,
    output logic       on_cmd,
    output logic       fault_active,
    output logic [1:0] fault_code,
    output logic [1:0] retry_cnt,
    output logic       lockout
);

    localparam int            CW          = cnt_width(COOLDOWN_CYC);
    localparam logic [CW-1:0] COOL_LAST   = CW'(COOLDOWN_CYC - 1);
    localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRY);

    // Fault priority: battery outranks input power, which outranks timeout.
    function automatic logic [1:0] encode_fault(input logic bat,
                                                input logic pow,
                                                input logic wd);
        if (bat) return FC_LOW_BAT;
        if (pow) return FC_LOW_POW;
        if (wd)  return FC_PU_TIMEOUT;
        return FC_NONE;
    endfunction

    logic on_f;
    logic low_bat_f;
    logic low_pow_f;
    logic wd_timeout;
    logic fault_now;

    sup_state_t    state;
    sup_state_t    state_next;
    logic          fault_active_next;
    logic [1:0]    fault_code_next;
    logic [1:0]    retry_next;
    logic [CW-1:0] cool_cnt;
    logic [CW-1:0] cool_cnt_next;

    pmic_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_on (
        .clk       (clk),
        .reset     (reset),
        .raw       (on_off_raw),
        .filt_next (on_f)
    );

    pmic_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_bat (
        .clk       (clk),
        .reset     (reset),
        .raw       (low_bat_raw),
        .filt_next (low_bat_f)
    );

    pmic_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pow (
        .clk       (clk),
        .reset     (reset),
        .raw       (low_pow_raw),
        .filt_next (low_pow_f)
    );

`ifdef PMIC_SUP_WATCHDOG_EN
    localparam int            PW      = cnt_width(PU_TIMEOUT);
    localparam logic [PW-1:0] PU_LAST = PW'(PU_TIMEOUT - 1);

    logic [PW-1:0] pu_cnt;
    logic [PW-1:0] pu_cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pu_cnt <= '0;
        end else begin
            pu_cnt <= pu_cnt_next;
        end
    end

    // Counts only while in POWER_UP and holds at its terminal value.
    always_comb begin
        pu_cnt_next = '0;
        if (state == ST_POWER_UP) begin
            pu_cnt_next = (pu_cnt == PU_LAST) ? pu_cnt : pu_cnt + PW'(1);
        end
    end

    assign wd_timeout = (state == ST_POWER_UP) && (pu_cnt == PU_LAST) && !seq_ready;
`else
    // No watchdog: constant-false for any legal PU_TIMEOUT.
    assign wd_timeout = (PU_TIMEOUT < 0);
`endif

    assign fault_now = low_bat_f || low_pow_f || wd_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_OFF;
            fault_active <= 1'b0;
            fault_code   <= FC_NONE;
            retry_cnt    <= '0;
            cool_cnt     <= '0;
        end else begin
            state        <= state_next;
            fault_active <= fault_active_next;
            fault_code   <= fault_code_next;
            retry_cnt    <= retry_next;
            cool_cnt     <= cool_cnt_next;
        end
    end

    always_comb begin
        state_next        = state;
        fault_active_next = fault_active;
        fault_code_next   = fault_code;
        retry_next        = retry_cnt;
        cool_cnt_next     = '0;
        unique case (state)
            ST_OFF: begin
                // A fault still present after cooldown keeps us here.
                if (on_f && !(low_bat_f || low_pow_f)) begin
                    state_next = ST_POWER_UP;
                end
            end
            ST_POWER_UP, ST_RUNNING: begin
                // Fault outranks a simultaneous OFF request.
                if (fault_now) begin
                    state_next        = ST_SHUTDOWN;
                    fault_active_next = 1'b1;
                    fault_code_next   = encode_fault(low_bat_f, low_pow_f, wd_timeout);
                end else if (!on_f) begin
                    state_next = ST_SHUTDOWN;
                end else if ((state == ST_POWER_UP) && seq_ready) begin
                    state_next = ST_RUNNING;
                end
            end
            ST_SHUTDOWN: begin
                if (seq_idle) begin
                    if (!fault_active) begin
                        state_next = ST_OFF;
                        retry_next = '0;
                    end else if (retry_cnt < RETRY_LIMIT) begin
                        state_next = ST_COOLDOWN;
                        retry_next = retry_cnt + 2'd1;
                    end else begin
                        state_next = ST_LOCKOUT;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cool_cnt == COOL_LAST) begin
                    state_next        = ST_OFF;
                    fault_active_next = 1'b0;
                    fault_code_next   = FC_NONE;
                end else begin
                    cool_cnt_next = cool_cnt + CW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (!on_f) begin
                    state_next        = ST_OFF;
                    retry_next        = '0;
                    fault_active_next = 1'b0;
                    fault_code_next   = FC_NONE;
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    assign on_cmd  = (state == ST_POWER_UP) || (state == ST_RUNNING);
    assign lockout = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_pmic_power_supervisor.sv
module tb_pmic_power_supervisor;

    localparam int D = 4;
    localparam int C = 8;
    localparam int R = 2;
    localparam int T = 20;
    localparam int LAT = 2 + D;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       on_off_raw = 1'b0;
    logic       low_bat_raw = 1'b0;
    logic       low_pow_raw = 1'b0;
    logic       seq_ready = 1'b0;
    logic       seq_idle = 1'b0;
    logic       on_cmd;
    logic       fault_active;
    logic [1:0] fault_code;
    logic [1:0] retry_cnt;
    logic       lockout;

    int total = 0;
    int bad = 0;

    // Reference filter: raw history per posedge, and the filtered level
    // it implies (value changes once the D raw samples taken 2..D+1 edges
    // ago all agree on the other level).
    logic h_on[$];
    logic h_bat[$];
    logic h_pow[$];
    logic m_on = 1'b0;
    logic m_bat = 1'b0;
    logic m_pow = 1'b0;

    always #5 clk = ~clk;

    pmic_power_supervisor #(
        .DEBOUNCE_CYC (D),
        .COOLDOWN_CYC (C),
        .MAX_RETRY    (R),
        .PU_TIMEOUT   (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .on_off_raw   (on_off_raw),
        .low_bat_raw  (low_bat_raw),
        .low_pow_raw  (low_pow_raw),
        .seq_ready    (seq_ready),
        .seq_idle     (seq_idle),
        .on_cmd       (on_cmd),
        .fault_active (fault_active),
        .fault_code   (fault_code),
        .retry_cnt    (retry_cnt),
        .lockout      (lockout)
    );

    function automatic logic window(input logic h[$], input logic cur);
        int n;
        n = h.size();
        if (n < D + 2) return cur;
        for (int i = n - D - 2; i <= n - 3; i++) begin
            if (h[i] != h[n-3]) return cur;
        end
        return h[n-3];
    endfunction

    task automatic tick();
        @(posedge clk);
        h_on.push_back(on_off_raw);
        h_bat.push_back(low_bat_raw);
        h_pow.push_back(low_pow_raw);
        m_on  = window(h_on, m_on);
        m_bat = window(h_bat, m_bat);
        m_pow = window(h_pow, m_pow);
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Power up from OFF (no faults) and reach RUNNING.
    task automatic power_up_to_running(input string tag);
        on_off_raw = 1'b1;
        seq_idle   = 1'b0;
        if (m_on) begin
            chk1({tag, "_already_on"}, on_cmd, 1'b1);
        end else begin
            repeat (LAT) begin
                tick();
                chk1({tag, "_pu_on_cmd"}, on_cmd, m_on);
            end
        end
        repeat ($urandom_range(1, 4)) begin
            tick();
            chk1({tag, "_pu_hold"}, on_cmd, 1'b1);
        end
        seq_ready = 1'b1;
        tick();
        seq_ready = 1'b0;
        chk1({tag, "_run"}, on_cmd, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "simulation time bound exceeded");
    end

    initial begin
        int n;

        // ---- reset state
        repeat (3) @(negedge clk);
        chk1("rst_on_cmd", on_cmd, 1'b0);
        chk1("rst_fault_active", fault_active, 1'b0);
        chk2("rst_fault_code", fault_code, 2'd0);
        chk2("rst_retry_cnt", retry_cnt, 2'd0);
        chk1("rst_lockout", lockout, 1'b0);
        reset = 1'b1;

        // ---- glitch filter: pulses shorter than D never reach on_cmd
        for (int g = 0; g < 4; g++) begin
            n = (g == 0) ? 3 : int'($urandom_range(1, D - 1));
            on_off_raw = 1'b1;
            repeat (n) begin
                tick();
                chk1("glitch_on_cmd", on_cmd, m_on);
            end
            on_off_raw = 1'b0;
            repeat (LAT + $urandom_range(0, 3)) begin
                tick();
                chk1("glitch_on_cmd", on_cmd, m_on);
            end
        end
        chk1("glitch_final", on_cmd, 1'b0);

        // ---- clean cycle
        power_up_to_running("clean");
        on_off_raw = 1'b0;
        repeat (LAT) begin
            tick();
            chk1("clean_off_on_cmd", on_cmd, m_on);
        end
        repeat ($urandom_range(1, 5)) begin
            tick();
            chk1("clean_sd_wait", on_cmd, 1'b0);
        end
        seq_idle = 1'b1;
        tick();
        seq_idle = 1'b0;
        chk2("clean_retry", retry_cnt, 2'd0);
        chk1("clean_fault_active", fault_active, 1'b0);

        // ---- fault retry on low_pow
        power_up_to_running("f1");
        low_pow_raw = 1'b1;
        repeat (LAT) begin
            tick();
            chk2("f1_code", fault_code, m_pow ? 2'd2 : 2'd0);
            chk1("f1_on_cmd", on_cmd, !m_pow);
        end
        chk1("f1_fault_active", fault_active, 1'b1);
        repeat ($urandom_range(1, 5)) begin
            tick();
            chk2("f1_sd_retry", retry_cnt, 2'd0);
        end
        low_pow_raw = 1'b0;
        seq_idle = 1'b1;
        tick();
        seq_idle = 1'b0;
        chk2("f1_cool_retry", retry_cnt, 2'd1);
        for (int k = 1; k <= C; k++) begin
            tick();
            chk1("f1_cool_fault_active", fault_active, (k < C));
            chk2("f1_cool_code", fault_code, (k < C) ? 2'd2 : 2'd0);
            chk1("f1_cool_on_cmd", on_cmd, 1'b0);
        end
        tick();
        chk1("f1_restart_on_cmd", on_cmd, 1'b1);
        chk2("f1_restart_retry", retry_cnt, 2'd1);

        // ---- second fault on low_bat, still present after cooldown
        seq_ready = 1'b1;
        tick();
        seq_ready = 1'b0;
        low_bat_raw = 1'b1;
        repeat (LAT) tick();
        chk2("f2_code", fault_code, 2'd1);
        chk1("f2_on_cmd", on_cmd, 1'b0);
        seq_idle = 1'b1;
        tick();
        seq_idle = 1'b0;
        chk2("f2_retry", retry_cnt, 2'd2);
        repeat (C) tick();
        chk1("f2_cool_done", fault_active, 1'b0);
        repeat ($urandom_range(2, 6)) begin
            tick();
            chk1("f2_blocked_on_cmd", on_cmd, 1'b0);
        end
        low_bat_raw = 1'b0;
        repeat (LAT) begin
            tick();
            chk1("f2_release_on_cmd", on_cmd, !m_bat);
        end

        // ---- third fault with retries exhausted -> lockout
        seq_ready = 1'b1;
        tick();
        seq_ready = 1'b0;
        low_pow_raw = 1'b1;
        repeat (LAT) tick();
        chk2("f3_code", fault_code, 2'd2);
        low_pow_raw = 1'b0;
        seq_idle = 1'b1;
        tick();
        seq_idle = 1'b0;
        chk1("f3_lockout", lockout, 1'b1);
        chk2("f3_retry", retry_cnt, 2'd2);
        repeat ($urandom_range(3, 10)) begin
            tick();
            chk1("f3_lock_hold", lockout, 1'b1);
            chk2("f3_lock_code", fault_code, 2'd2);
            chk1("f3_lock_on_cmd", on_cmd, 1'b0);
        end
        on_off_raw = 1'b0;
        repeat (LAT) begin
            tick();
            chk1("f3_lock_exit", lockout, m_on);
        end
        chk2("f3_exit_retry", retry_cnt, 2'd0);
        chk2("f3_exit_code", fault_code, 2'd0);
        chk1("f3_exit_fault_active", fault_active, 1'b0);
        on_off_raw = 1'b1;
        repeat (LAT) begin
            tick();
            chk1("f3_repower_on_cmd", on_cmd, m_on);
        end
        chk1("f3_repower_final", on_cmd, 1'b1);

        // ---- priority: low_bat, low_pow and OFF filtered together
        seq_ready = 1'b1;
        tick();
        seq_ready = 1'b0;
        low_bat_raw = 1'b1;
        low_pow_raw = 1'b1;
        on_off_raw  = 1'b0;
        repeat (LAT) tick();
        chk2("prio_code", fault_code, 2'd1);
        chk1("prio_fault_active", fault_active, 1'b1);
        chk1("prio_on_cmd", on_cmd, 1'b0);
        low_bat_raw = 1'b0;
        low_pow_raw = 1'b0;
        seq_idle = 1'b1;
        tick();
        seq_idle = 1'b0;
        chk2("prio_retry", retry_cnt, 2'd1);
        repeat (C + 2) tick();
        chk1("prio_off_on_cmd", on_cmd, 1'b0);
        chk1("prio_off_fault_active", fault_active, 1'b0);

        // ---- power-up watchdog (seq_ready never arrives)
        on_off_raw = 1'b1;
        repeat (LAT) tick();
        chk1("wd_enter_pu", on_cmd, 1'b1);
        repeat (T - 1) tick();
        chk2("wd_before_code", fault_code, 2'd0);
        chk1("wd_before_on_cmd", on_cmd, 1'b1);
        tick();
`ifdef PMIC_SUP_WATCHDOG_EN
        chk2("wd_code", fault_code, 2'd3);
        chk1("wd_fault_active", fault_active, 1'b1);
        chk1("wd_on_cmd", on_cmd, 1'b0);
`else
        repeat (10) tick();
        chk2("wd_off_code", fault_code, 2'd0);
        chk1("wd_off_fault_active", fault_active, 1'b0);
        chk1("wd_off_on_cmd", on_cmd, 1'b1);
`endif

        // ---- asynchronous reset mid-sequence, retry_cnt currently 1
        reset = 1'b0;
        #1;
        chk1("mrst_on_cmd", on_cmd, 1'b0);
        chk1("mrst_fault_active", fault_active, 1'b0);
        chk2("mrst_fault_code", fault_code, 2'd0);
        chk2("mrst_retry", retry_cnt, 2'd0);
        chk1("mrst_lockout", lockout, 1'b0);
        repeat (2) @(negedge clk);
        h_on.delete();
        h_bat.delete();
        h_pow.delete();
        m_on  = 1'b0;
        m_bat = 1'b0;
        m_pow = 1'b0;
        reset = 1'b1;
        repeat (LAT) begin
            tick();
            chk1("mrst_repower_on_cmd", on_cmd, m_on);
        end
        chk1("mrst_repower_final", on_cmd, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmic_power_supervisor.md
PMIC_POWER_SUPERVISOR -- requirements
Module: pmic_power_supervisor

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16: consecutive stable cycles before a filtered input changes.
REQ-002 Parameter COOLDOWN_CYC, default 1024: cycles held in COOLDOWN after a fault shutdown.
REQ-003 Parameter MAX_RETRY, default 3: fault restarts allowed before LOCKOUT.
REQ-004 Parameter PU_TIMEOUT, default 4096: cycles allowed for seq_ready after power-up starts (watchdog build only).
REQ-005 clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 on_off_raw  input  1  user ON/OFF switch, unsynchronised.
REQ-008 low_bat_raw  input  1  battery-low comparator, unsynchronised.
REQ-009 low_pow_raw  input  1  input-power-low comparator, unsynchronised.
REQ-010 seq_ready  input  1  Ready from the LDO sequencer.
REQ-011 seq_idle  input  1  high when the sequencer has all LDOs off.
REQ-012 on_cmd  output  1  filtered ON request to the sequencer.
REQ-013 fault_active  output  1  high from fault detection until COOLDOWN ends.
REQ-014 fault_code  output  2  0 none, 1 low_bat, 2 low_pow, 3 power-up timeout.
REQ-015 retry_cnt  output  2  fault restarts taken since the last clean OFF; saturates at MAX_RETRY.
REQ-016 lockout  output  1  high in LOCKOUT.

Function
REQ-017 Each raw input passes through a 2-flop synchroniser, then a debouncer that updates its filtered value only after DEBOUNCE_CYC consecutive identical synchronised samples.
REQ-018 Latency: a clean raw edge reaches the filtered value in 2+DEBOUNCE_CYC cycles; a glitch shorter than DEBOUNCE_CYC produces no change.
REQ-019 States: OFF, POWER_UP, RUNNING, SHUTDOWN, COOLDOWN, LOCKOUT.
REQ-020 OFF: on_cmd=0; filtered ON with no filtered fault moves to POWER_UP.
REQ-021 POWER_UP: on_cmd=1; seq_ready=1 moves to RUNNING; filtered OFF moves to SHUTDOWN with fault_code 0.
REQ-022 RUNNING: on_cmd=1; filtered OFF moves to SHUTDOWN with fault_code 0.
REQ-023 In POWER_UP or RUNNING, a filtered fault moves to SHUTDOWN, sets fault_active and latches fault_code.
REQ-024 Simultaneous low_bat and low_pow latch code 1; fault outranks a simultaneous OFF.
REQ-025 SHUTDOWN: on_cmd=0; waits for seq_idle=1.
REQ-026 SHUTDOWN exit, no fault: go to OFF and clear retry_cnt.
REQ-027 SHUTDOWN exit, fault, retry_cnt<MAX_RETRY: increment retry_cnt and go to COOLDOWN.
REQ-028 SHUTDOWN exit, fault, retry_cnt=MAX_RETRY: go to LOCKOUT.
REQ-029 COOLDOWN: on_cmd=0; counts COOLDOWN_CYC cycles, then clears fault_active and fault_code and goes to OFF; a still-present fault blocks power-up from OFF.
REQ-030 LOCKOUT: on_cmd=0 and fault_code held; exits to OFF, clearing retry_cnt and fault state, only after filtered OFF is seen.
REQ-031 Counters are sized by $clog2 of their parameter and never wrap; a terminal count holds until the state exits.

Reset
REQ-032 While reset=0: state=OFF, all debouncer filtered values 0, all counters 0, and every output 0.
REQ-033 A reset mid-sequence takes effect immediately without waiting for seq_idle; on release the block starts in OFF.

Configuration
REQ-034 With PMIC_SUP_WATCHDOG_EN defined, a counter runs in POWER_UP; reaching PU_TIMEOUT with seq_ready=0 is a fault with code 3, handled per REQ-023 to REQ-030.
REQ-035 Without PMIC_SUP_WATCHDOG_EN, there is no timeout counter, code 3 is never produced, and POWER_UP waits indefinitely.

Structure
REQ-036 The state enum, fault_code constants and default parameter values live in shared package pmic_pkg.
REQ-037 The synchroniser and debouncer form one sub-module, pmic_debounce, instantiated three times.

Verification
(Bench parameters: DEBOUNCE_CYC=4, COOLDOWN_CYC=8, MAX_RETRY=2, PU_TIMEOUT=20.)
REQ-038 Clean cycle: on_off_raw 0->1 -> on_cmd=1 after 6 cycles; seq_ready=1 -> RUNNING; on_off_raw=0, then seq_idle=1 -> OFF, retry_cnt=0.
REQ-039 Glitch filter: a 3-cycle on_off_raw pulse -> on_cmd stays 0.
REQ-040 Fault retry: in RUNNING, low_pow_raw=1 -> fault_code=2 and on_cmd=0 six cycles later; seq_idle=1 -> COOLDOWN for 8 cycles, retry_cnt=1.
REQ-041 Lockout: a third fault with retry_cnt=2 -> lockout=1; toggle on_off_raw 0 then 1 -> one power-up from OFF.
REQ-042 Priority: low_bat, low_pow and OFF filtered on the same cycle -> fault_code=1, fault_active=1.
REQ-043 Watchdog (macro defined): seq_ready held 0 -> fault_code=3 twenty cycles after entering POWER_UP; with the macro undefined -> no fault.
